vram_fetch: RTL and testbench



---
 rtl/vga_text_pkg.sv | 44 ++++
 rtl/vram_fetch_if.sv | 37 +++
 rtl/vram_rd_arb.sv | 68 ++++++
 rtl/vram_fetch.sv | 157 +++++++++++++++
 tb/tb_vram_fetch.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode VRAM fetch path.
// Contents: geometry constants (COLS, ROWS, CELL_CLKS, ADDR_W, LINE_BYTES),
// slot indices within a cell period, the fetch state enum, the read-tag
// enum that labels each VRAM read with its issuer, and a helper that
// computes a text row's base byte address.
package vga_text_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int CELL_CLKS  = 8;
    localparam int ADDR_W     = 13;
    localparam int LINE_BYTES = 2 * COLS;

    localparam int SLOT_W = $clog2(CELL_CLKS);
    localparam int COL_W  = 7;

    localparam logic [SLOT_W-1:0] SLOT_CHAR       = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_ATTR       = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_HOST_FIRST = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] SLOT_LAST       = SLOT_W'(CELL_CLKS - 1);
    localparam logic [COL_W-1:0]  COL_LAST        = COL_W'(COLS - 1);
    localparam logic [4:0]        ROW_LIMIT       = 5'(ROWS);

    typedef enum logic {
        IDLE,
        FETCH
    } fetchState_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CHAR,
        TAG_ATTR,
        TAG_HOST
    } readTag_t;

    // Row base = row * 160 = row * 128 + row * 32, built from shifts so no
    // multiplier is inferred.
    function automatic logic [ADDR_W-1:0] rowBase(input logic [4:0] row);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 7) + (r << 5);
    endfunction

endpackage

// File: rtl/vram_fetch_if.sv
// Bus bundle between the VRAM fetch block and its surroundings.
// Carries the line-start request, the VRAM read port (address out, data
// back one clock later), the fetched cell outputs and the host read
// handshake.
//   slave  : the fetch block (drives readoutAddr, cell and host results)
//   master : the environment (drives lineStart/rowIndex, readoutData,
//            host requests)
interface vram_fetch_if;
    import vga_text_pkg::*;

    logic              lineStart;
    logic [4:0]        rowIndex;
    logic [ADDR_W-1:0] readoutAddr;
    logic [7:0]        readoutData;
    logic [7:0]        cellChar;
    logic [7:0]        cellAttr;
    logic [COL_W-1:0]  cellCol;
    logic              cellValid;
    logic              hostRdReq;
    logic [ADDR_W-1:0] hostRdAddr;
    logic              hostRdBusy;
    logic [7:0]        hostRdData;
    logic              hostRdValid;

    modport slave (
        input  lineStart, rowIndex, readoutData, hostRdReq, hostRdAddr,
        output readoutAddr, cellChar, cellAttr, cellCol, cellValid,
               hostRdBusy, hostRdData, hostRdValid
    );

    modport master (
        output lineStart, rowIndex, readoutData, hostRdReq, hostRdAddr,
        input  readoutAddr, cellChar, cellAttr, cellCol, cellValid,
               hostRdBusy, hostRdData, hostRdValid
    );

endinterface

// File: rtl/vram_rd_arb.sv
// Read-port arbiter for the single VRAM read port.
// Chooses what is presented on readoutAddr each cycle (cell fetch slots win,
// host reads take any cycle left free), holds the last address when nothing
// is issued, and tags every issued read so the returning byte one clock
// later can be routed to its owner.
// Ports:
//   clk, rst     clock, async active-high reset
//   fetchTag     TAG_CHAR/TAG_ATTR when the sequencer owns this cycle
//   fetchAddr    address for the fetch read
//   hostWant     a latched host read is waiting to be issued
//   hostAddr     latched host read address
//   flush        drop cell-fetch tags (row restart); host tags survive
//   readoutAddr  VRAM read address
//   hostGrant    host read is issued this cycle
//   retTag       owner of the byte on readoutData this cycle
module vram_rd_arb
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  readTag_t          fetchTag,
    input  logic [ADDR_W-1:0] fetchAddr,
    input  logic              hostWant,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic              flush,
    output logic [ADDR_W-1:0] readoutAddr,
    output logic              hostGrant,
    output readTag_t          retTag
);

    readTag_t          issueTag;
    logic [ADDR_W-1:0] lastAddr;

    // NOTE: every signal driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        issueTag    = TAG_NONE;
        readoutAddr = lastAddr;
        hostGrant   = 1'b0;
        if (fetchTag != TAG_NONE) begin
            issueTag    = fetchTag;
            readoutAddr = fetchAddr;
        end else if (hostWant) begin
            issueTag    = TAG_HOST;
            readoutAddr = hostAddr;
            hostGrant   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastAddr <= '0;
            retTag   <= TAG_NONE;
        end else begin
            lastAddr <= readoutAddr;
            // A row restart discards the partial cell's returning bytes, but
            // a host read already on the port still gets its data.
            if (flush && issueTag != TAG_HOST) begin
                retTag <= TAG_NONE;
            end else begin
                retTag <= issueTag;
            end
        end
    end

endmodule

// File: rtl/vram_fetch.sv
// Display-side VRAM reader for 80x30 text mode.
// On lineStart it walks the 80 cells of the requested row, one cell every
// CELL_CLKS clocks: char address in slot 0, attr address in slot 1, the
// cell is presented with a one-cycle cellValid in slot 3. Slots 2..7, and
// every idle cycle, are available to a single outstanding host read.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       vram_fetch_if.slave: lineStart/rowIndex, readoutAddr/Data,
//             cellChar/cellAttr/cellCol/cellValid, host read handshake
module vram_fetch
    import vga_text_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    vram_fetch_if.slave    bus
);

    fetchState_t       state, stateNext;
    logic [SLOT_W-1:0] slot, slotNext;
    logic [COL_W-1:0]  col, colNext;
    logic [ADDR_W-1:0] base, baseNext;
    logic [ADDR_W-1:0] cellAddr;
    logic              lineOk;

    readTag_t          fetchTag;
    logic [ADDR_W-1:0] fetchAddr;
    logic              hostGrant;
    readTag_t          retTag;

    logic [7:0]        charHold;
    logic [7:0]        cellCharQ, cellAttrQ;
    logic [COL_W-1:0]  cellColQ;
    logic              cellValidQ;
    logic              hostBusy, hostIssued;
    logic [ADDR_W-1:0] hostAddrQ;
    logic [7:0]        hostRdDataQ;
    logic              hostRdValidQ;

    assign lineOk   = bus.lineStart && (bus.rowIndex < ROW_LIMIT);
    assign cellAddr = base + {{(ADDR_W-COL_W-1){1'b0}}, col, 1'b0};

    always_comb begin
        stateNext = state;
        slotNext  = slot;
        colNext   = col;
        baseNext  = base;
        fetchTag  = TAG_NONE;
        fetchAddr = cellAddr;
        if (state == FETCH) begin
            if (slot == SLOT_CHAR) begin
                fetchTag = TAG_CHAR;
            end else if (slot == SLOT_ATTR) begin
                fetchTag  = TAG_ATTR;
                fetchAddr = cellAddr + ADDR_W'(1);
            end
            if (slot == SLOT_LAST) begin
                slotNext = '0;
                if (col == COL_LAST) begin
                    stateNext = IDLE;
                    colNext   = '0;
                end else begin
                    colNext = col + 1'b1;
                end
            end else begin
                slotNext = slot + 1'b1;
            end
        end
        // A valid lineStart restarts from any state; rows past the screen
        // are ignored and the current walk carries on.
        if (lineOk) begin
            stateNext = FETCH;
            slotNext  = '0;
            colNext   = '0;
            baseNext  = rowBase(bus.rowIndex);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            slot  <= '0;
            col   <= '0;
            base  <= '0;
        end else begin
            state <= stateNext;
            slot  <= slotNext;
            col   <= colNext;
            base  <= baseNext;
        end
    end

    vram_rd_arb arb (
        .clk         (clk),
        .rst         (rst),
        .fetchTag    (fetchTag),
        .fetchAddr   (fetchAddr),
        .hostWant    (hostBusy && !hostIssued),
        .hostAddr    (hostAddrQ),
        .flush       (lineOk),
        .readoutAddr (bus.readoutAddr),
        .hostGrant   (hostGrant),
        .retTag      (retTag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            charHold     <= '0;
            cellCharQ    <= '0;
            cellAttrQ    <= '0;
            cellColQ     <= '0;
            cellValidQ   <= 1'b0;
            hostBusy     <= 1'b0;
            hostIssued   <= 1'b0;
            hostAddrQ    <= '0;
            hostRdDataQ  <= '0;
            hostRdValidQ <= 1'b0;
        end else begin
            cellValidQ   <= 1'b0;
            hostRdValidQ <= 1'b0;

            if (retTag == TAG_CHAR) begin
                charHold <= bus.readoutData;
            end
            // The attr byte completes the cell; a restart in this same cycle
            // abandons it. col still names this cell until slot 7 ends.
            if (retTag == TAG_ATTR && !lineOk) begin
                cellCharQ  <= charHold;
                cellAttrQ  <= bus.readoutData;
                cellColQ   <= col;
                cellValidQ <= 1'b1;
            end

            if (hostGrant) begin
                hostIssued <= 1'b1;
            end
            if (retTag == TAG_HOST) begin
                hostRdDataQ  <= bus.readoutData;
                hostRdValidQ <= 1'b1;
                hostBusy     <= 1'b0;
                hostIssued   <= 1'b0;
            end
            if (bus.hostRdReq && !hostBusy) begin
                hostBusy  <= 1'b1;
                hostAddrQ <= bus.hostRdAddr;
            end
        end
    end

    assign bus.cellChar    = cellCharQ;
    assign bus.cellAttr    = cellAttrQ;
    assign bus.cellCol     = cellColQ;
    assign bus.cellValid   = cellValidQ;
    assign bus.hostRdBusy  = hostBusy;
    assign bus.hostRdData  = hostRdDataQ;
    assign bus.hostRdValid = hostRdValidQ;

endmodule

// File: tb/tb_vram_fetch.sv
// Self-checking bench for vram_fetch.
// A VRAM model returns byte[a] = a[7:0] one clock after the address.
// A cycle-count model derives, from the lineStart cycle and slot arithmetic,
// when each cell must appear and what it holds, and when each host read
// must issue and return; one negedge process compares every cycle.
// Directed sections pin the model with hand-computed literals, then a
// randomized section mixes row starts (valid and invalid) with host reads.
module tb_vram_fetch;
    import vga_text_pkg::*;

    logic clk = 1'b0;
    logic rst;

    vram_fetch_if vif ();

    vram_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vram(input logic [ADDR_W-1:0] a);
        return a[7:0];
    endfunction

    // VRAM read port: data for the address seen in cycle t is driven in t+1.
    logic [ADDR_W-1:0] addrPrev = '0;
    always @(negedge clk) addrPrev = vif.readoutAddr;
    always @(posedge clk) begin
        #1;
        vif.readoutData = vram(addrPrev);
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int                cyc = 0;
    bit                active = 1'b0;
    int                lineCyc = 0;
    int                baseM = 0;
    int                k, slotM, colM;
    bit                fetching, busyNow;
    bit                hPend = 1'b0, hFly = 1'b0;
    int                hIssueCyc = 0;
    logic [ADDR_W-1:0] hAddrM = '0;
    logic [7:0]        hDataM = '0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst readoutAddr", 32'(vif.readoutAddr), 32'(0));
            check("rst cellValid", 32'(vif.cellValid), 32'(0));
            check("rst hostRdBusy", 32'(vif.hostRdBusy), 32'(0));
            check("rst hostRdValid", 32'(vif.hostRdValid), 32'(0));
            check("rst hostRdData", 32'(vif.hostRdData), 32'(0));
            active = 1'b0;
            hPend  = 1'b0;
            hFly   = 1'b0;
            hDataM = '0;
        end else begin
            k        = cyc - lineCyc - 1;
            fetching = active && k >= 0 && k < COLS * CELL_CLKS;
            slotM    = k % CELL_CLKS;
            colM     = k / CELL_CLKS;

            if (fetching && slotM == 3) begin
                check("cellValid", 32'(vif.cellValid), 32'(1));
                check("cellCol", 32'(vif.cellCol), colM);
                check("cellChar", 32'(vif.cellChar), 32'(vram(ADDR_W'(baseM + 2 * colM))));
                check("cellAttr", 32'(vif.cellAttr), 32'(vram(ADDR_W'(baseM + 2 * colM + 1))));
            end else begin
                check("cellValid idle", 32'(vif.cellValid), 32'(0));
            end
            if (fetching && slotM == 0)
                check("char addr", 32'(vif.readoutAddr), baseM + 2 * colM);
            if (fetching && slotM == 1)
                check("attr addr", 32'(vif.readoutAddr), baseM + 2 * colM + 1);

            if (hFly && cyc == hIssueCyc + 2) begin
                check("hostRdValid", 32'(vif.hostRdValid), 32'(1));
                hDataM = vram(hAddrM);
                hFly   = 1'b0;
            end else begin
                check("hostRdValid idle", 32'(vif.hostRdValid), 32'(0));
            end
            busyNow = hPend || hFly;
            check("hostRdBusy", 32'(vif.hostRdBusy), 32'(busyNow));
            check("hostRdData", 32'(vif.hostRdData), 32'(hDataM));

            // Host issues in the first cycle not owned by a char/attr read.
            if (hPend && !(fetching && slotM < 2)) begin
                check("host addr", 32'(vif.readoutAddr), 32'(hAddrM));
                hPend     = 1'b0;
                hFly      = 1'b1;
                hIssueCyc = cyc;
            end
            if (vif.hostRdReq && !busyNow) begin
                hPend  = 1'b1;
                hAddrM = vif.hostRdAddr;
            end
            if (vif.lineStart && int'(vif.rowIndex) < ROWS) begin
                active  = 1'b1;
                lineCyc = cyc;
                baseM   = int'(vif.rowIndex) * LINE_BYTES;
            end
        end
        cyc++;
    end

    // ------------------------------ stimulus -------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulseLine(input int row);
        vif.lineStart = 1'b1;
        vif.rowIndex  = 5'(row);
        tick();
        vif.lineStart = 1'b0;
    endtask

    task automatic waitCell(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            if (vif.cellValid) got = 1'b1;
            else tick();
        end
    endtask

    task automatic waitHost(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            if (vif.hostRdValid) got = 1'b1;
            else tick();
        end
    endtask

    int         t0, cnt, accepted, returned;
    bit         got;
    logic [7:0] lastChar, lastAttr;
    logic [6:0] lastCol;

    initial begin
        vif.lineStart  = 1'b0;
        vif.rowIndex   = '0;
        vif.hostRdReq  = 1'b0;
        vif.hostRdAddr = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Row fetch, row 2.
        pulseLine(2);
        t0 = cyc;
        check("row2 first addr", 32'(vif.readoutAddr), 32'(320));
        waitCell(20, got);
        check("row2 first cell seen", 32'(got), 32'(1));
        check("row2 latency", cyc - t0, 3);
        check("row2 cell0 char", 32'(vif.cellChar), 32'(8'h40));
        check("row2 cell0 attr", 32'(vif.cellAttr), 32'(8'h41));
        cnt = 1;
        lastChar = '0; lastAttr = '0; lastCol = '0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (vif.cellValid) begin
                cnt++;
                lastChar = vif.cellChar;
                lastAttr = vif.cellAttr;
                lastCol  = vif.cellCol;
            end
        end
        check("row2 cell count", cnt, 80);
        check("row2 last col", 32'(lastCol), 32'(79));
        check("row2 last char", 32'(lastChar), 32'(8'hDE));
        check("row2 last attr", 32'(lastAttr), 32'(8'hDF));
        check("idle addr hold", 32'(vif.readoutAddr), 32'(13'h1DF));

        // Idle host read.
        vif.hostRdReq  = 1'b1;
        vif.hostRdAddr = 13'h12AB;
        t0 = cyc;
        tick();
        vif.hostRdReq = 1'b0;
        check("idle host busy", 32'(vif.hostRdBusy), 32'(1));
        check("idle host issue", 32'(vif.readoutAddr), 32'(13'h12AB));
        waitHost(10, got);
        check("idle host seen", 32'(got), 32'(1));
        check("idle host latency", cyc - t0, 3);
        check("idle host data", 32'(vif.hostRdData), 32'(8'hAB));
        check("idle host busy low", 32'(vif.hostRdBusy), 32'(0));
        repeat (3) tick();

        // Host read latched in slot 0 of column 2, row 3.
        pulseLine(3);
        repeat (16) tick();
        check("row3 col2 addr", 32'(vif.readoutAddr), 32'(484));
        vif.hostRdReq  = 1'b1;
        vif.hostRdAddr = 13'h0A5C;
        t0 = cyc;
        tick();
        vif.hostRdReq = 1'b0;
        waitHost(10, got);
        check("fetch host seen", 32'(got), 32'(1));
        check("fetch host latency", cyc - t0, 4);
        check("fetch host data", 32'(vif.hostRdData), 32'(8'h5C));
        repeat (700) tick();

        // Back-to-back host reads across a full row.
        pulseLine(int'($urandom_range(0, ROWS - 1)));
        cnt = 0; accepted = 0; returned = 0;
        for (int i = 0; i < COLS * CELL_CLKS + 10; i++) begin
            if (vif.cellValid) cnt++;
            if (vif.hostRdValid) returned++;
            vif.hostRdReq = !vif.hostRdBusy;
            if (!vif.hostRdBusy) accepted++;
            vif.hostRdAddr = ADDR_W'($urandom_range(0, 8191));
            tick();
        end
        vif.hostRdReq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vif.hostRdValid) returned++;
            tick();
        end
        check("b2b cell count", cnt, 80);
        check("b2b host results", returned, accepted);

        // Restart at column 40, slot 1 of row 1, into row 5.
        pulseLine(1);
        repeat (321) tick();
        check("row1 col40 attr addr", 32'(vif.readoutAddr), 32'(241));
        vif.lineStart = 1'b1;
        vif.rowIndex  = 5'd5;
        t0 = cyc;
        tick();
        vif.lineStart = 1'b0;
        waitCell(20, got);
        check("restart cell seen", 32'(got), 32'(1));
        check("restart latency", cyc - t0, 4);
        check("restart col", 32'(vif.cellCol), 32'(0));
        check("restart char", 32'(vif.cellChar), 32'(8'h20));
        check("restart attr", 32'(vif.cellAttr), 32'(8'h21));

        // Reset mid-FETCH with a host read outstanding.
        repeat (100) tick();
        vif.hostRdReq  = 1'b1;
        vif.hostRdAddr = 13'h0777;
        tick();
        vif.hostRdReq = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst readoutAddr", 32'(vif.readoutAddr), 32'(0));
        check("async rst cellChar", 32'(vif.cellChar), 32'(0));
        check("async rst cellAttr", 32'(vif.cellAttr), 32'(0));
        check("async rst cellCol", 32'(vif.cellCol), 32'(0));
        check("async rst cellValid", 32'(vif.cellValid), 32'(0));
        check("async rst hostRdBusy", 32'(vif.hostRdBusy), 32'(0));
        check("async rst hostRdData", 32'(vif.hostRdData), 32'(0));
        check("async rst hostRdValid", 32'(vif.hostRdValid), 32'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Out-of-range row is ignored while idle.
        pulseLine(30);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (vif.cellValid) cnt++;
            tick();
        end
        check("row30 no cells", cnt, 0);
        check("row30 addr idle", 32'(vif.readoutAddr), 32'(0));

        // Out-of-range row mid-fetch leaves the row running.
        pulseLine(4);
        cnt = 0;
        for (int i = 0; i < 700; i++) begin
            if (i == 50) vif.lineStart = 1'b1;
            else vif.lineStart = 1'b0;
            vif.rowIndex = 5'd31;
            if (vif.cellValid) cnt++;
            tick();
        end
        vif.lineStart = 1'b0;
        check("row4 survives row31", cnt, 80);

        // Randomized mix; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            vif.lineStart  = ($urandom_range(0, 299) == 0);
            vif.rowIndex   = 5'($urandom_range(0, 31));
            vif.hostRdReq  = ($urandom_range(0, 2) == 0);
            vif.hostRdAddr = ADDR_W'($urandom_range(0, 8191));
            tick();
        end
        vif.lineStart = 1'b0;
        vif.hostRdReq = 1'b0;
        repeat (700) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
